// File: rtl/iq_switch_sequencer_if.sv
`timescale 1ns/1ps
// Control/capture bundle between the sweep controller, the accumulator and the sequencer.
// Optional comp_diff member exists only when IQ_SEQ_DIFF_EN is defined.
interface iq_switch_sequencer_if #(
    parameter int ACC_W      = 48,
    parameter int NUM_PHASES = 2,
    parameter int CNT_W      = 16
);
    localparam int SEL_W = $clog2(NUM_PHASES);

    logic                          start;
    logic                          abort;
    logic                          continuous;
    logic [CNT_W-1:0]              settle_cycles;
    logic [CNT_W-1:0]              dwell_cycles;
    logic signed [ACC_W-1:0]       acc_in;
    logic                          acc_clr;
    logic [SEL_W-1:0]              rf_sel;
    logic [NUM_PHASES*ACC_W-1:0]   comp_data;
    logic                          comp_valid;
    logic                          busy;
`ifdef IQ_SEQ_DIFF_EN
    logic signed [ACC_W:0]         comp_diff;

    modport master (
        output start, abort, continuous, settle_cycles, dwell_cycles, acc_in,
        input  acc_clr, rf_sel, comp_data, comp_valid, busy, comp_diff
    );

    modport slave (
        input  start, abort, continuous, settle_cycles, dwell_cycles, acc_in,
        output acc_clr, rf_sel, comp_data, comp_valid, busy, comp_diff
    );
`else
    modport master (
        output start, abort, continuous, settle_cycles, dwell_cycles, acc_in,
        input  acc_clr, rf_sel, comp_data, comp_valid, busy
    );

    modport slave (
        input  start, abort, continuous, settle_cycles, dwell_cycles, acc_in,
        output acc_clr, rf_sel, comp_data, comp_valid, busy
    );
`endif
endinterface

// File: rtl/iq_switch_sequencer.sv
`timescale 1ns/1ps
// RF-switch/IQ sequencer: per phase settle, 1-cycle clear, integrate; sweep = NUM_PHASES*(settle+1+max(dwell,1)) cycles to comp_valid.
// No backpressure, abort drops to IDLE next cycle; IQ_SEQ_DIFF_EN adds comp_diff = slot[1]-slot[0].
module iq_switch_sequencer #(
    parameter int ACC_W      = 48,
    parameter int NUM_PHASES = 2,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    iq_switch_sequencer_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_PHASES);
    localparam logic [SEL_W-1:0] LAST_PHASE = SEL_W'(NUM_PHASES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CLEAR, INTEG} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [SEL_W-1:0]        phase, phase_nxt;
    logic [CNT_W-1:0]        settle_q, settle_nxt;
    logic [CNT_W-1:0]        dwell_q, dwell_nxt;
    logic                    cont_q, cont_nxt;
    logic                    capture;
    logic                    sweep_done;
    logic                    enter_phase;
    logic [CNT_W-1:0]        entry_settle;
    logic [CNT_W-1:0]        dwell_last;
    logic signed [ACC_W-1:0] slot [NUM_PHASES];
    logic                    comp_valid_q;

    // Integration counts down to zero, so a zero dwell behaves as one cycle.
    assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            phase    <= '0;
            settle_q <= '0;
            dwell_q  <= '0;
            cont_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            phase    <= phase_nxt;
            settle_q <= settle_nxt;
            dwell_q  <= dwell_nxt;
            cont_q   <= cont_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        phase_nxt    = phase;
        settle_nxt   = settle_q;
        dwell_nxt    = dwell_q;
        cont_nxt     = cont_q;
        capture      = 1'b0;
        sweep_done   = 1'b0;
        enter_phase  = 1'b0;
        entry_settle = settle_q;

        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    settle_nxt   = bus.settle_cycles;
                    dwell_nxt    = bus.dwell_cycles;
                    cont_nxt     = bus.continuous;
                    phase_nxt    = '0;
                    enter_phase  = 1'b1;
                    entry_settle = bus.settle_cycles;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = CLEAR;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            CLEAR: begin
                state_nxt = INTEG;
                cnt_nxt   = dwell_last;
            end
            INTEG: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    capture = 1'b1;
                    if (phase == LAST_PHASE) begin
                        sweep_done = 1'b1;
                        phase_nxt  = '0;
                        // A back-to-back restart re-samples the configuration like a fresh start.
                        if (cont_q) begin
                            settle_nxt   = bus.settle_cycles;
                            dwell_nxt    = bus.dwell_cycles;
                            cont_nxt     = bus.continuous;
                            enter_phase  = 1'b1;
                            entry_settle = bus.settle_cycles;
                        end else begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end
                    end else begin
                        phase_nxt   = phase + SEL_W'(1);
                        enter_phase = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                phase_nxt = '0;
            end
        endcase

        if (enter_phase) begin
            if (entry_settle == '0) begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end else begin
                state_nxt = SETTLE;
                cnt_nxt   = entry_settle - CNT_W'(1);
            end
        end

        // Abort overrides everything, including a capture due on the same edge.
        if (bus.abort && state != IDLE) begin
            state_nxt  = IDLE;
            cnt_nxt    = '0;
            phase_nxt  = '0;
            settle_nxt = settle_q;
            dwell_nxt  = dwell_q;
            cont_nxt   = cont_q;
            capture    = 1'b0;
            sweep_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PHASES; k++) begin
                slot[k] <= '0;
            end
            comp_valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_PHASES; k++) begin
                if (capture && phase == SEL_W'(k)) begin
                    slot[k] <= bus.acc_in;
                end
            end
            comp_valid_q <= sweep_done;
        end
    end

    for (genvar g = 0; g < NUM_PHASES; g++) begin : g_pack
        assign bus.comp_data[g*ACC_W +: ACC_W] = slot[g];
    end

    assign bus.acc_clr    = (state == CLEAR);
    assign bus.busy       = (state != IDLE);
    assign bus.rf_sel     = phase;
    assign bus.comp_valid = comp_valid_q;

`ifdef IQ_SEQ_DIFF_EN
    logic signed [ACC_W-1:0] s0_new;
    logic signed [ACC_W-1:0] s1_new;
    logic [ACC_W:0]          comp_diff_q;

    // Difference uses the post-capture slot values so it lines up with comp_valid.
    always_comb begin
        s0_new = (capture && phase == SEL_W'(0)) ? bus.acc_in : slot[0];
        s1_new = (capture && phase == SEL_W'(1)) ? bus.acc_in : slot[1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            comp_diff_q <= '0;
        end else if (sweep_done) begin
            comp_diff_q <= {s1_new[ACC_W-1], s1_new} - {s0_new[ACC_W-1], s0_new};
        end
    end

    assign bus.comp_diff = comp_diff_q;
`endif
endmodule

// File: tb/tb_iq_switch_sequencer.sv
`timescale 1ns/1ps
// Randomized bench: per-cycle expected timeline built from sweep arithmetic, plus a comp_valid scoreboard.
module tb_iq_switch_sequencer;
    localparam int ACC_W = 48;
    localparam int NP    = 4;
    localparam int CNT_W = 16;
    localparam int SEL_W = $clog2(NP);
    localparam int DW    = NP * ACC_W;
    localparam int CW    = DW + 1;
    localparam int MAXC  = 8192;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    iq_switch_sequencer_if #(.ACC_W(ACC_W), .NUM_PHASES(NP), .CNT_W(CNT_W)) bus ();

    iq_switch_sequencer #(.ACC_W(ACC_W), .NUM_PHASES(NP), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [ACC_W-1:0]        acc_tab  [MAXC+2];
    logic [SEL_W-1:0]        exp_sel  [MAXC];
    logic                    exp_busy [MAXC];
    logic                    exp_clr  [MAXC];
    logic                    exp_cv   [MAXC];
    logic [DW-1:0]           exp_data [MAXC];
    logic signed [ACC_W-1:0] mslot    [NP];
    logic [DW-1:0]           sb_data  [$];
    logic [ACC_W:0]          sb_diff  [$];
    logic [DW-1:0]           mon_d;
    logic [ACC_W:0]          mon_df;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // acc_tab[e] is the accumulator value sampled by the DUT at edge e.
    always @(negedge clk) bus.acc_in = (cyc + 1 <= MAXC + 1) ? acc_tab[cyc+1] : '0;

    task automatic chk(input string nm, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            chk("rf_sel", CW'(bus.rf_sel), CW'(exp_sel[cyc]));
            chk("busy", CW'(bus.busy), CW'(exp_busy[cyc]));
            chk("acc_clr", CW'(bus.acc_clr), CW'(exp_clr[cyc]));
            chk("comp_valid", CW'(bus.comp_valid), CW'(exp_cv[cyc]));
            chk("comp_data", CW'(bus.comp_data), CW'(exp_data[cyc]));
            if (bus.comp_valid === 1'b1) begin
                if (sb_data.size() == 0) begin
                    chk("sb_unexpected_valid", CW'(bus.comp_valid), CW'(0));
                end else begin
                    mon_d = sb_data.pop_front();
                    chk("sweep_data", CW'(bus.comp_data), CW'(mon_d));
`ifdef IQ_SEQ_DIFF_EN
                    mon_df = sb_diff.pop_front();
                    chk("comp_diff", CW'($unsigned(bus.comp_diff)), CW'(mon_df));
`endif
                end
            end
`ifdef IQ_SEQ_DIFF_EN
            if (cyc <= 3) chk("comp_diff_rst", CW'($unsigned(bus.comp_diff)), CW'(0));
`endif
        end
    end

    // Entered right after a negedge; plans the expected timeline, then drives inputs edge by edge.
    // ab_sel: -1 none, -2 random edge, >0 fixed offset from the accept edge (abort or reset edge).
    task automatic run_seq(input int s, input int d, input int n, input int ab_sel,
                           input bit use_rst, input bit noise, input bit corner);
        int t0, l, sw, t_end, a, x_last, base, e, tcv;
        logic [DW-1:0] snap;
        logic signed [63:0] dl;
        t0    = cyc + 1;
        l     = s + 1 + ((d == 0) ? 1 : d);
        sw    = NP * l;
        t_end = t0 + n * sw;
        if (ab_sel == -2)     a = t0 + int'($urandom_range(1, n * sw));
        else if (ab_sel > 0)  a = t0 + ab_sel;
        else                  a = MAXC + 10;
        x_last = (a < t_end) ? a : t_end;
        if (corner) begin
            acc_tab[t0 + l]     = {1'b1, {(ACC_W-1){1'b0}}};
            acc_tab[t0 + 2 * l] = {1'b0, {(ACC_W-1){1'b1}}};
        end
        for (int si = 0; si < n; si++) begin
            base = t0 + si * sw;
            for (int k = 0; k < NP; k++) begin
                for (int c = base + k * l; c < base + (k + 1) * l; c++) begin
                    if (c < a) begin
                        exp_sel[c]  = SEL_W'(k);
                        exp_busy[c] = 1'b1;
                        exp_clr[c]  = (c == base + k * l + s);
                    end
                end
                e = base + (k + 1) * l;
                if (e < a) begin
                    mslot[k] = acc_tab[e];
                    for (int c = e; c < MAXC; c++) exp_data[c][k*ACC_W +: ACC_W] = acc_tab[e];
                end
            end
            tcv = base + sw;
            if (tcv < a) begin
                exp_cv[tcv] = 1'b1;
                for (int k = 0; k < NP; k++) snap[k*ACC_W +: ACC_W] = mslot[k];
                sb_data.push_back(snap);
                dl = longint'(mslot[1]) - longint'(mslot[0]);
                sb_diff.push_back(dl[ACC_W:0]);
            end
        end
        if (use_rst && a < MAXC) begin
            for (int k = 0; k < NP; k++) mslot[k] = '0;
            for (int c = a; c < MAXC; c++) exp_data[c] = '0;
        end
        for (int x = t0; x <= x_last; x++) begin
            bus.start      = (x == t0) || (noise && x > t0 && $urandom_range(0, 3) == 0);
            bus.abort      = !use_rst && (x == a);
            rst_n          = !(use_rst && (x == a));
            bus.continuous = (x < t0 + (n - 1) * sw);
            if (x == t0 || !noise || n > 1) begin
                bus.settle_cycles = CNT_W'(s);
                bus.dwell_cycles  = CNT_W'(d);
            end else begin
                bus.settle_cycles = CNT_W'($urandom_range(0, 9));
                bus.dwell_cycles  = CNT_W'($urandom_range(0, 9));
            end
            @(negedge clk);
        end
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        rst_n          = 1'b1;
        bus.continuous = 1'b0;
    endtask

    task automatic idle_gap(input int k, input bit ab_st);
        for (int i = 0; i < k; i++) begin
            bus.start = ab_st && (i == 0);
            bus.abort = ab_st && (i == 0);
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    initial begin
        logic [63:0] r;
        int s, d, n, ab;
        bit rs;
        for (int i = 0; i < MAXC + 2; i++) begin
            r = {$urandom(), $urandom()};
            acc_tab[i] = r[ACC_W-1:0];
        end
        for (int i = 0; i < MAXC; i++) begin
            exp_sel[i]  = '0;
            exp_busy[i] = 1'b0;
            exp_clr[i]  = 1'b0;
            exp_cv[i]   = 1'b0;
            exp_data[i] = '0;
        end
        for (int k = 0; k < NP; k++) mslot[k] = '0;
        rst_n             = 1'b0;
        bus.start         = 1'b0;
        bus.abort         = 1'b0;
        bus.continuous    = 1'b0;
        bus.settle_cycles = '0;
        bus.dwell_cycles  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_seq(4, 10, 1, -1, 1'b0, 1'b0, 1'b0);
        idle_gap(2, 1'b0);
        run_seq(0, 0, 1, -1, 1'b0, 1'b0, 1'b0);
        idle_gap(2, 1'b1);
        run_seq(2, 3, 3, -1, 1'b0, 1'b0, 1'b0);
        idle_gap(1, 1'b0);
        run_seq(3, 6, 1, 17, 1'b0, 1'b0, 1'b0);
        run_seq(3, 6, 1, 40, 1'b0, 1'b0, 1'b0);
        idle_gap(1, 1'b0);
        run_seq(2, 5, 1, 13, 1'b1, 1'b1, 1'b0);
        idle_gap(2, 1'b0);
        run_seq(1, 2, 1, -1, 1'b0, 1'b0, 1'b1);
        idle_gap(1, 1'b0);

        for (int i = 0; i < 30 && cyc < MAXC - 400; i++) begin
            s  = int'($urandom_range(0, 6));
            d  = int'($urandom_range(0, 8));
            n  = int'($urandom_range(1, 3));
            ab = ($urandom_range(0, 3) == 0) ? -2 : -1;
            rs = (ab == -2) && ($urandom_range(0, 1) == 1);
            run_seq(s, d, n, ab, rs, 1'b1, 1'b0);
            idle_gap(int'($urandom_range(0, 3)), $urandom_range(0, 4) == 0);
        end

        idle_gap(3, 1'b0);
        chk("sb_drained", CW'(sb_data.size()), CW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
